// File: rtl/avmm_button_led_pio_if.sv
// Avalon-MM slave bus bundle for the button/LED PIO.
interface avmm_button_led_pio_if;
  logic [2:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata,
    input  avs_readdata
  );

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata,
    output avs_readdata
  );
endinterface

// File: rtl/avmm_button_led_pio.sv
// Button/LED PIO: synchronised and debounced buttons, press-edge capture with
// maskable level interrupt, and LEDs with per-bit hardware blink.
module avmm_button_led_pio #(
  parameter int unsigned NUM_BTN         = 4,
  parameter int unsigned NUM_LED         = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned BTN_ACTIVE_LOW  = 1,
  parameter int unsigned BLINK_DIV       = 25000000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  avmm_button_led_pio_if.slave    bus,
  output logic                    irq,
  input  logic [NUM_BTN-1:0]      btn_in,
  output logic [NUM_LED-1:0]      led_out
);

  localparam int unsigned DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

  logic [NUM_BTN-1:0] btn_norm;
  logic [NUM_BTN-1:0] sync1;
  logic [NUM_BTN-1:0] sync2;
  logic [NUM_BTN-1:0] stable;
  logic [DEB_W-1:0]   deb_cnt [NUM_BTN];
  logic [NUM_BTN-1:0] deb_done;
  logic [NUM_BTN-1:0] btn_rise;
  logic [NUM_BTN-1:0] edge_cap;
  logic [NUM_BTN-1:0] irq_mask;
  logic [NUM_BTN-1:0] ecap_clr;
  logic [NUM_LED-1:0] led_reg;
  logic [NUM_LED-1:0] blink_en;
  logic [BLK_W-1:0]   blink_cnt;
  logic               blink_phase;
  logic [31:0]        rd_mux;
  logic [31:0]        readdata_q;
  logic               wr_led;
  logic               wr_mask;
  logic               wr_ecap;
  logic               wr_blink;
  logic               unused_wdata;

  // Normalise so that 1 always means pressed.
  assign btn_norm = (BTN_ACTIVE_LOW != 0) ? ~btn_in : btn_in;

  assign unused_wdata = ^bus.avs_writedata;

  // Two-flop synchroniser for the asynchronous button pins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_norm;
      sync2 <= sync1;
    end
  end

  // Debounce acceptance and press (0->1) detection per button.
  always_comb begin
    deb_done = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      deb_done[i] = (sync2[i] != stable[i]) && (deb_cnt[i] == DEB_LAST);
    end
    btn_rise = deb_done & sync2;
  end

  // Debounce counters and accepted stable levels.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        deb_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_BTN; i++) begin
        if (deb_done[i]) begin
          stable[i]  <= sync2[i];
          deb_cnt[i] <= '0;
        end else if (sync2[i] != stable[i]) begin
          deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  // Write decode.
  always_comb begin
    wr_led   = bus.avs_write && (bus.avs_address == 3'd1);
    wr_mask  = bus.avs_write && (bus.avs_address == 3'd2);
    wr_ecap  = bus.avs_write && (bus.avs_address == 3'd3);
    wr_blink = bus.avs_write && (bus.avs_address == 3'd4);
    ecap_clr = wr_ecap ? bus.avs_writedata[NUM_BTN-1:0] : '0;
  end

  // Control registers and edge capture; a new press beats a same-cycle clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      led_reg  <= '0;
      irq_mask <= '0;
      blink_en <= '0;
      edge_cap <= '0;
    end else begin
      if (wr_led)   led_reg  <= bus.avs_writedata[NUM_LED-1:0];
      if (wr_mask)  irq_mask <= bus.avs_writedata[NUM_BTN-1:0];
      if (wr_blink) blink_en <= bus.avs_writedata[NUM_LED-1:0];
      edge_cap <= (edge_cap & ~ecap_clr) | btn_rise;
    end
  end

  // Read mux over the pre-write register contents.
  always_comb begin
    rd_mux = '0;
    case (bus.avs_address)
      3'd0:    rd_mux = 32'(stable);
      3'd1:    rd_mux = 32'(led_reg);
      3'd2:    rd_mux = 32'(irq_mask);
      3'd3:    rd_mux = 32'(edge_cap);
      3'd4:    rd_mux = 32'(blink_en);
      3'd5:    rd_mux = {16'(NUM_LED), 16'(NUM_BTN)};
      default: rd_mux = '0;
    endcase
  end

  // Read data register (latency 1, held until the next read) and interrupt.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata_q <= '0;
      irq        <= 1'b0;
    end else begin
      if (bus.avs_read) readdata_q <= rd_mux;
      irq <= |(edge_cap & irq_mask);
    end
  end

  assign bus.avs_readdata = readdata_q;

  // Free-running blink divider; phase toggles on every wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      led_out     <= '0;
    end else begin
      if (blink_cnt == BLK_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + BLK_W'(1);
      end
      led_out <= led_reg & (~blink_en | {NUM_LED{blink_phase}});
    end
  end

endmodule

// File: tb/tb_avmm_button_led_pio.sv
// Bench for avmm_button_led_pio: directed scenarios plus random traffic,
// checked every cycle against a behavioural model of the peripheral.
module tb_avmm_button_led_pio;
  localparam int unsigned NB   = 4;
  localparam int unsigned NL   = 8;
  localparam int unsigned DEB  = 4;
  localparam int unsigned BDIV = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [NB-1:0] btn_in;
  logic [NL-1:0] led_out;
  logic          irq;

  avmm_button_led_pio_if bus();

  avmm_button_led_pio #(
    .NUM_BTN(NB), .NUM_LED(NL), .DEBOUNCE_CYCLES(DEB),
    .BTN_ACTIVE_LOW(1), .BLINK_DIV(BDIV)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus),
    .irq(irq), .btn_in(btn_in), .led_out(led_out)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned failures = 0;

  // Reference model state
  logic [NB-1:0] hist [$];
  logic [NB-1:0] m_stable, m_mask, m_ecap;
  logic [NL-1:0] m_led, m_ben, m_ledout;
  logic          m_irq;
  logic [31:0]   m_rd;
  int            m_run [NB];
  int unsigned   n_edges;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] reg_val(input logic [2:0] a);
    case (a)
      3'd0:    return 32'(m_stable);
      3'd1:    return 32'(m_led);
      3'd2:    return 32'(m_mask);
      3'd3:    return 32'(m_ecap);
      3'd4:    return 32'(m_ben);
      3'd5:    return 32'h0008_0004;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_clear();
    m_stable = '0; m_mask = '0; m_ecap = '0;
    m_led = '0; m_ben = '0; m_ledout = '0;
    m_irq = 1'b0; m_rd = '0; n_edges = 0;
    for (int i = 0; i < NB; i++) m_run[i] = 0;
    hist = {};
    hist.push_back('0);
    hist.push_back('0);
  endtask

  // One clock: advance the model with the inputs seen at the edge, then check outputs.
  task automatic tick();
    logic [NB-1:0] seen, rise;
    logic          phase;
    @(posedge clk);
    n_edges++;
    phase = 1'(((n_edges - 1) / BDIV) % 2);
    if (bus.avs_read) m_rd = reg_val(bus.avs_address);
    m_irq    = |(m_ecap & m_mask);
    m_ledout = m_led & (~m_ben | {NL{phase}});
    // The debouncer sees the pressed level from two edges earlier.
    seen = hist.pop_front();
    hist.push_back(~btn_in);
    rise = '0;
    for (int i = 0; i < NB; i++) begin
      if (seen[i] != m_stable[i]) begin
        m_run[i]++;
        if (m_run[i] == int'(DEB)) begin
          m_stable[i] = seen[i];
          m_run[i]    = 0;
          rise[i]     = seen[i];
        end
      end else begin
        m_run[i] = 0;
      end
    end
    if (bus.avs_write) begin
      case (bus.avs_address)
        3'd1: m_led  = bus.avs_writedata[NL-1:0];
        3'd2: m_mask = bus.avs_writedata[NB-1:0];
        3'd3: m_ecap = m_ecap & ~bus.avs_writedata[NB-1:0];
        3'd4: m_ben  = bus.avs_writedata[NL-1:0];
        default: ;
      endcase
    end
    m_ecap = m_ecap | rise;
    #1;
    chk("irq", 32'(irq), 32'(m_irq));
    chk("led_out", 32'(led_out), 32'(m_ledout));
    chk("readdata", bus.avs_readdata, m_rd);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #2;
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_led", 32'(led_out), 32'h0);
    chk("rst_rd", bus.avs_readdata, 32'h0);
    model_clear();
    reset_n = 1'b1;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    bus.avs_address = a; bus.avs_writedata = d; bus.avs_write = 1'b1;
    tick();
    bus.avs_write = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    bus.avs_address = a; bus.avs_read = 1'b1;
    tick();
    bus.avs_read = 1'b0;
    d = bus.avs_readdata;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  logic [31:0] d;
  logic [3:0]  lo [32];

  initial begin
    btn_in = '1;
    bus.avs_address = '0; bus.avs_read = 1'b0; bus.avs_write = 1'b0; bus.avs_writedata = '0;
    do_reset();

    // Register map after reset
    for (int a = 0; a < 6; a++) begin
      bus_read(3'(a), d);
      chk("reset_map", d, (a == 5) ? 32'h0008_0004 : 32'h0);
    end

    // Debounce latency: accepted at the sixth edge, visible to the seventh read
    bus_write(3'd2, 32'h1);
    btn_in[0] = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      bus_read(3'd0, d);
      chk("deb_latency", 32'(d[0]), (k == 7) ? 32'h1 : 32'h0);
    end
    chk("irq_on_press", 32'(irq), 32'h1);
    bus_read(3'd3, d);
    chk("ecap_press", d, 32'h1);

    // Three-cycle glitch on btn1 is rejected
    btn_in[1] = 1'b0;
    ticks(3);
    btn_in[1] = 1'b1;
    ticks(8);
    bus_read(3'd0, d);
    chk("glitch_data", d, 32'h1);

    // Release does not capture an edge
    btn_in[0] = 1'b1;
    ticks(8);
    bus_read(3'd3, d);
    chk("ecap_release", d, 32'h1);
    bus_read(3'd0, d);
    chk("data_release", d, 32'h0);

    // Write-1-to-clear drops irq on the following cycle
    bus_write(3'd3, 32'h1);
    tick();
    chk("irq_cleared", 32'(irq), 32'h0);
    bus_read(3'd3, d);
    chk("ecap_cleared", d, 32'h0);

    // Masked press captures but keeps irq low
    btn_in[2] = 1'b0;
    ticks(8);
    bus_read(3'd3, d);
    chk("ecap_btn2", d, 32'h4);
    chk("irq_masked", 32'(irq), 32'h0);

    // Clear on the same edge that stable[0] rises: the set wins
    bus_write(3'd3, 32'h4);
    btn_in[0] = 1'b0;
    ticks(5);
    bus_write(3'd3, 32'h1);
    bus_read(3'd3, d);
    chk("ecap_race", d, 32'h1);
    btn_in = '1;
    ticks(8);

    // Blink: high nibble steady, low nibble toggles 0x0/0x5 every 8 cycles
    bus_write(3'd1, 32'hA5);
    bus_write(3'd4, 32'h0F);
    tick();
    for (int j = 0; j < 32; j++) begin
      tick();
      lo[j] = led_out[3:0];
      chk("blink_hi", 32'(led_out[7:4]), 32'hA);
    end
    for (int j = 8; j < 32; j++) begin
      chk("blink_lo", 32'(lo[j]), 32'(lo[j-8] ^ 4'h5));
    end

    // Read latency and read/write collision
    bus_write(3'd1, 32'h3C);
    bus_read(3'd1, d);
    chk("rd_latency", d, 32'h3C);
    bus.avs_address = 3'd1; bus.avs_writedata = 32'h77;
    bus.avs_read = 1'b1; bus.avs_write = 1'b1;
    tick();
    bus.avs_read = 1'b0; bus.avs_write = 1'b0;
    chk("rw_old", bus.avs_readdata, 32'h3C);
    bus_read(3'd1, d);
    chk("rw_new", d, 32'h77);

    // Random buttons and bus traffic
    for (int c = 0; c < 800; c++) begin
      int unsigned op;
      if ($urandom_range(0, 5) == 0) btn_in[$urandom_range(0, NB-1)] ^= 1'b1;
      op = $urandom_range(0, 3);
      bus.avs_address   = 3'($urandom_range(0, 7));
      bus.avs_writedata = $urandom;
      bus.avs_read      = (op == 1 || op == 3);
      bus.avs_write     = (op == 2 || op == 3);
      tick();
    end
    bus.avs_read = 1'b0; bus.avs_write = 1'b0;

    // Reset mid-run discards everything
    btn_in = '1;
    bus_write(3'd1, 32'hFF);
    bus_write(3'd4, 32'h00);
    tick();
    chk("pre_reset_led", 32'(led_out), 32'hFF);
    do_reset();
    for (int a = 0; a < 6; a++) begin
      bus_read(3'(a), d);
      chk("midrst_map", d, (a == 5) ? 32'h0008_0004 : 32'h0);
    end
    chk("midrst_led", 32'(led_out), 32'h0);
    chk("midrst_irq", 32'(irq), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
